ram_writer: RTL

- Write-side companion to the board's 4-word x 4-bit lookup ROM. Owns a small writable memory that holds the same table.
- At reset it self-loads the default table (3, 6, 9, C).
- Afterwards it accepts single-word writes over a valid/ready handshake and serves a registered read port.
- Sits in top between SWI (address/data/strobe source) and LED (read data, status).

---
 rtl/ram_writer_pkg.sv | 20 ++
 rtl/ram_writer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ram_writer_pkg.sv
// rtl/ram_writer_pkg.sv - shared types, widths and default-table function for ram_writer
package ram_writer_pkg;

    localparam int NBITS_ADDR = 2;
    localparam int NBITS_DATA = 4;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Default table entry i is 3*(i+1), truncated to the word width
    function automatic logic [NBITS_DATA-1:0] default_word(input logic [31:0] i);
        logic [31:0] v;
        v = 32'd3 * (i + 32'd1);
        return v[NBITS_DATA-1:0];
    endfunction

endpackage

// File: rtl/ram_writer.sv
// rtl/ram_writer.sv - self-loading writable lookup table with handshake write port and registered read
module ram_writer
    import ram_writer_pkg::*;
#(
    parameter int NWORDS     = 4,
    parameter int NBITS_ADDR = ram_writer_pkg::NBITS_ADDR,
    parameter int NBITS_DATA = ram_writer_pkg::NBITS_DATA,
    parameter int NBITS_CNT  = 8
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    input  logic [NBITS_ADDR-1:0] wr_addr,
    input  logic [NBITS_DATA-1:0] wr_data,
    output logic                  wr_ready,
    input  logic [NBITS_ADDR-1:0] rd_addr,
    output logic [NBITS_DATA-1:0] rd_data,
    output logic                  init_busy,
    output logic [NBITS_CNT-1:0]  wr_count
);

    // init_ptr carries one extra bit so it can count past the last word
    localparam logic [NBITS_ADDR:0] LAST_PTR = (NBITS_ADDR+1)'(NWORDS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [NBITS_ADDR:0]   r_init_ptr;
    logic [NBITS_DATA-1:0] r_mem [NWORDS];
    logic [NBITS_DATA-1:0] r_rd_data;
    logic [NBITS_CNT-1:0]  r_wr_count;
    logic                  w_init_we;
    logic                  w_host_we;
    logic                  w_wr_ready;
    logic                  w_init_busy;

    // State register
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        w_wr_ready   = 1'b0;
        w_init_busy  = 1'b0;
        w_init_we    = 1'b0;
        w_host_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_busy = 1'b1;
                w_init_we   = 1'b1;
                if (r_init_ptr == LAST_PTR) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_wr_ready = 1'b1;
                if (wr_valid) begin
                    w_host_we    = 1'b1;
                    w_state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Load pointer walks the table once after each reset
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_init_ptr <= '0;
        end else if (w_init_we) begin
            r_init_ptr <= r_init_ptr + 1'b1;
        end
    end

    // Memory array: cleared on reset, filled by the load, then updated by host writes
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_init_we) begin
            r_mem[r_init_ptr[NBITS_ADDR-1:0]] <= default_word(32'(r_init_ptr));
        end else if (w_host_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; sees the pre-write word when addresses collide on an edge
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    // Saturating count of accepted host writes
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_count <= '0;
        end else if (w_host_we && (r_wr_count != {NBITS_CNT{1'b1}})) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

    assign wr_ready  = w_wr_ready;
    assign init_busy = w_init_busy;
    assign rd_data   = r_rd_data;
    assign wr_count  = r_wr_count;

endmodule
